mem_access_ctrl: RTL and testbench

MEM-stage data-memory controller for the 5-stage RISC-V pipeline. Takes the load/store command held in the EX/MEM pipeline register and runs it on a request/grant/response data bus. Stalls the front of the pipeline until the access completes. Delivers a sign- or zero-extended load result to MEM/WB, and flags misaligned accesses and bus timeouts.

---
 rtl/mem_ctrl_pkg.sv | 45 ++++
 rtl/mem_access_ctrl_load_extend.sv | 38 +++
 rtl/mem_access_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory controller:
// FSM state encoding, RISC-V load/store funct3 codes, default bus timeout
// and the small size/lane helpers used by the controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned TIMEOUT_DEFAULT = 16;

  // Halfwords need an even address, words a 4-byte aligned address.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    logic mis;
    mis = 1'b0;
    case (f3)
      F3_H, F3_HU: mis = lane[0];
      F3_W:        mis = (lane != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Byte enables for an access of the given size starting at byte lane 'lane'.
  // Unknown size codes are treated as full-word accesses.
  function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] lane);
    logic [3:0] be;
    case (f3)
      F3_B, F3_BU: be = 4'b0001 << lane;
      F3_H, F3_HU: be = 4'b0011 << lane;
      default:     be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// Load result extraction: picks the byte/halfword at the given lane of a
// read word and sign- or zero-extends it. Purely combinational so it can be
// shared with the MEM/WB forwarding path.
module load_extend
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection; halfword lanes are 0 or 2, so lane[1] picks the half.
  always_comb begin
    case (lane_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Extension by access size and signedness; words pass through.
  always_comb begin
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'h000000, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'h0000, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory controller. Runs the load/store held in EX/MEM on a
// req/gnt/rvalid data bus, stalls the front of the pipeline until the access
// completes and delivers the extended load result for one cycle in DONE.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no access in flight; latch an aligned access from EX/MEM
//   REQ   | bus_req_o high with latched fields, waiting for bus_gnt_i
//   WAIT  | load granted, waiting for bus_rvalid_i
//   DONE  | one-cycle result/error strobe; pipeline advances this edge
//
// Only WIDTH = 32 is supported.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read_i,
  input  logic             mem_write_i,
  input  logic [WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0] store_data_i,
  input  logic [2:0]       funct3_i,
  output logic             bus_req_o,
  output logic             bus_we_o,
  output logic [WIDTH-1:0] bus_addr_o,
  output logic [WIDTH-1:0] bus_wdata_o,
  output logic [3:0]       bus_be_o,
  input  logic             bus_gnt_i,
  input  logic             bus_rvalid_i,
  input  logic [WIDTH-1:0] bus_rdata_i,
  output logic             stall_o,
  output logic [WIDTH-1:0] load_data_o,
  output logic             load_valid_o,
  output logic             misalign_o,
  output logic             bus_err_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic             we_q, we_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       lane_q, lane_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] load_data_q, load_data_d;
  logic             load_valid_q, load_valid_d;
  logic             bus_err_q, bus_err_d;

  logic             access;
  logic             misaligned;
  logic             start;
  logic             timeout_hit;
  logic [WIDTH-1:0] lane_wdata;
  logic [WIDTH-1:0] ext_data;

  // A load wins when both read and write are flagged.
  assign access      = mem_read_i | mem_write_i;
  assign misaligned  = is_misaligned(funct3_i, addr_i[1:0]);
  assign start       = (state_q == ST_IDLE) & access & ~misaligned;
  assign timeout_hit = (cnt_q == CNT_LAST);

  load_extend u_load_extend (
    .rdata_i  (bus_rdata_i),
    .lane_i   (lane_q),
    .funct3_i (funct3_q),
    .data_o   (ext_data)
  );

  // Store data replicated across all lanes; byte enables pick the live ones.
  always_comb begin
    case (funct3_i)
      F3_B:    lane_wdata = {4{store_data_i[7:0]}};
      F3_H:    lane_wdata = {2{store_data_i[15:0]}};
      default: lane_wdata = store_data_i;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latched bus fields, timeout counter and DONE-cycle result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= 4'b0000;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      lane_q       <= 2'b00;
      cnt_q        <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      lane_q       <= lane_d;
      cnt_q        <= cnt_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      bus_err_q    <= bus_err_d;
    end
  end

  // Next state and next datapath values. Bus progress takes priority over
  // the timeout when both happen in the same cycle.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    lane_d       = lane_q;
    cnt_d        = cnt_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    bus_err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_REQ;
          addr_d   = {addr_i[WIDTH-1:2], 2'b00};
          we_d     = mem_write_i & ~mem_read_i;
          wdata_d  = (mem_write_i & ~mem_read_i) ? lane_wdata : '0;
          be_d     = byte_enables(funct3_i, addr_i[1:0]);
          funct3_d = funct3_i;
          lane_d   = addr_i[1:0];
          cnt_d    = '0;
        end
      end
      ST_REQ: begin
        if (bus_gnt_i) begin
          state_d = we_q ? ST_DONE : ST_WAIT;
          cnt_d   = cnt_q + 1'b1;
        end else if (timeout_hit) begin
          state_d     = ST_DONE;
          bus_err_d   = 1'b1;
          load_data_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (bus_rvalid_i) begin
          state_d      = ST_DONE;
          load_data_d  = ext_data;
          load_valid_d = 1'b1;
        end else if (timeout_hit) begin
          state_d     = ST_DONE;
          bus_err_d   = 1'b1;
          load_data_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Combinational outputs: request strobe, pipeline stall, misalign flag.
  always_comb begin
    bus_req_o  = (state_q == ST_REQ);
    stall_o    = start | (state_q == ST_REQ) | (state_q == ST_WAIT);
    misalign_o = (state_q == ST_IDLE) & access & misaligned;
  end

  assign bus_we_o     = we_q;
  assign bus_addr_o   = addr_q;
  assign bus_wdata_o  = wdata_q;
  assign bus_be_o     = be_q;
  assign load_data_o  = load_data_q;
  assign load_valid_o = load_valid_q;
  assign bus_err_o    = bus_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a table of load/store vectors
// driven through a programmable bus responder, with scoreboards for the
// granted bus request and for the DONE-cycle load/error result.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_i, mem_write_i;
  logic [31:0] addr_i, store_data_i;
  logic [2:0]  funct3_i;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i, bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        stall_o;
  logic [31:0] load_data_o;
  logic        load_valid_o, misalign_o, bus_err_o;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .addr_i       (addr_i),
    .store_data_i (store_data_i),
    .funct3_i     (funct3_i),
    .bus_req_o    (bus_req_o),
    .bus_we_o     (bus_we_o),
    .bus_addr_o   (bus_addr_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_be_o     (bus_be_o),
    .bus_gnt_i    (bus_gnt_i),
    .bus_rvalid_i (bus_rvalid_i),
    .bus_rdata_i  (bus_rdata_i),
    .stall_o      (stall_o),
    .load_data_o  (load_data_o),
    .load_valid_o (load_valid_o),
    .misalign_o   (misalign_o),
    .bus_err_o    (bus_err_o)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gnt_dly;    // REQ cycles before grant; 255 = never
    int          rv_dly;     // WAIT cycles before rvalid; 255 = never
    logic        mis;
    logic [3:0]  ex_be;
    logic        ex_we;
    logic [31:0] ex_wdata;
    logic        ex_ld;      // a DONE-cycle result/error is expected
    logic        ex_err;
    logic [31:0] ex_data;
    int          ex_stalls;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } ld_exp_t;

  localparam int NV = 21;
  vec_t     vecs[NV];
  bus_exp_t busq[$];
  ld_exp_t  ldq[$];

  int checks = 0;
  int errors = 0;

  int          gnt_dly = 0;
  int          rv_dly = 0;
  int          req_cnt = 0;
  int          rv_cnt = 0;
  bit          pending = 1'b0;
  logic [31:0] rdata_knob = 32'h0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
    end
  endtask

  // Bus responder; also checks the request fields at the grant cycle.
  initial begin
    bus_exp_t e;
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = 32'h0;
    forever begin
      @(negedge clk);
      bus_gnt_i    = 1'b0;
      bus_rvalid_i = 1'b0;
      bus_rdata_i  = 32'h5A5A5A5A;
      if (pending) begin
        if (rv_dly != 255 && rv_cnt == rv_dly) begin
          bus_rvalid_i = 1'b1;
          bus_rdata_i  = rdata_knob;
          pending      = 1'b0;
        end else begin
          rv_cnt++;
        end
      end
      if (bus_req_o && !rst) begin
        if (gnt_dly != 255 && req_cnt == gnt_dly) begin
          bus_gnt_i = 1'b1;
          req_cnt   = 0;
          if (busq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_grant: got request addr 0x%08h required no request", bus_addr_o);
          end else begin
            e = busq.pop_front();
            chk("bus_addr", bus_addr_o, e.addr);
            chk("bus_be", {28'h0, bus_be_o}, {28'h0, e.be});
            chk("bus_we", {31'h0, bus_we_o}, {31'h0, e.we});
            if (e.we) chk("bus_wdata", bus_wdata_o, e.wdata);
          end
          if (!bus_we_o) begin
            pending = 1'b1;
            rv_cnt  = 0;
          end
        end else begin
          req_cnt++;
        end
      end else begin
        req_cnt = 0;
      end
    end
  end

  // Result scoreboard: every load_valid/bus_err strobe must match a queued expectation.
  initial begin
    ld_exp_t e;
    forever begin
      @(negedge clk);
      if (load_valid_o || bus_err_o) begin
        if (ldq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got valid=%0b err=%0b data=0x%08h required no result",
                   load_valid_o, bus_err_o, load_data_o);
        end else begin
          e = ldq.pop_front();
          chk("result_err", {31'h0, bus_err_o}, {31'h0, e.err});
          chk("result_data", load_data_o, e.data);
          if (!e.err) chk("result_valid", {31'h0, load_valid_o}, 32'h1);
        end
      end
    end
  end

  task automatic run_vec(input int idx, input vec_t v);
    int       stalls;
    bit       saw_req;
    bit       done;
    bus_exp_t be;
    ld_exp_t  le;
    gnt_dly    = v.gnt_dly;
    rv_dly     = v.rv_dly;
    rdata_knob = v.rdata;
    pending    = 1'b0;
    if (!v.mis && v.gnt_dly != 255) begin
      be.addr  = {v.addr[31:2], 2'b00};
      be.be    = v.ex_be;
      be.we    = v.ex_we;
      be.wdata = v.ex_wdata;
      busq.push_back(be);
    end
    if (v.ex_ld) begin
      le.data = v.ex_data;
      le.err  = v.ex_err;
      ldq.push_back(le);
    end
    mem_read_i   = v.rd;
    mem_write_i  = v.wr;
    addr_i       = v.addr;
    store_data_i = v.wdata;
    funct3_i     = v.f3;
    stalls  = 0;
    saw_req = 1'b0;
    done    = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (c == 0) chk($sformatf("v%0d_misalign", idx), {31'h0, misalign_o}, {31'h0, v.mis});
      if (bus_req_o) saw_req = 1'b1;
      if (stall_o) stalls++;
      else done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL v%0d_timeout: got stall still high after 64 cycles required completion", idx);
    end
    chk($sformatf("v%0d_stalls", idx), stalls, v.ex_stalls);
    if (v.mis) chk($sformatf("v%0d_no_req", idx), {31'h0, saw_req}, 32'h0);
    @(posedge clk);
    #1;
    mem_read_i   = 1'b0;
    mem_write_i  = 1'b0;
    addr_i       = 32'h0;
    store_data_i = 32'h0;
    funct3_i     = 3'b000;
    @(posedge clk);
    #1;
  endtask

  // Reset lands while a load sits in WAIT; the late rvalid must be ignored.
  task automatic reset_mid_wait();
    bit       seen_req;
    bit       in_wait;
    bus_exp_t be;
    gnt_dly    = 0;
    rv_dly     = 3;
    rdata_knob = 32'h13572468;
    pending    = 1'b0;
    be.addr  = 32'h800;
    be.be    = 4'hF;
    be.we    = 1'b0;
    be.wdata = 32'h0;
    busq.push_back(be);
    mem_read_i   = 1'b1;
    mem_write_i  = 1'b0;
    addr_i       = 32'h800;
    store_data_i = 32'h0;
    funct3_i     = 3'b010;
    seen_req = 1'b0;
    in_wait  = 1'b0;
    for (int c = 0; c < 20 && !in_wait; c++) begin
      @(negedge clk);
      if (bus_req_o) seen_req = 1'b1;
      else if (seen_req && stall_o) in_wait = 1'b1;
    end
    if (!in_wait) begin
      checks++;
      errors++;
      $display("FAIL rst_reach_wait: got no WAIT cycle within 20 cycles required WAIT");
    end
    @(posedge clk);
    #1;
    rst        = 1'b1;
    mem_read_i = 1'b0;
    addr_i     = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rst_stall", {31'h0, stall_o}, 32'h0);
      chk("rst_load_valid", {31'h0, load_valid_o}, 32'h0);
      chk("rst_bus_req", {31'h0, bus_req_o}, 32'h0);
    end
    pending = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by 500us required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    mem_read_i   = 1'b0;
    mem_write_i  = 1'b0;
    addr_i       = 32'h0;
    store_data_i = 32'h0;
    funct3_i     = 3'b000;

    //          rd    wr    f3      addr        wdata          rdata         gnt  rv   mis   be     we    ex_wdata       ld    err   ex_data        stalls
    vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h00000000, 32'hDEADBEEF, 0,   0,   1'b0, 4'hF, 1'b0, 32'h00000000, 1'b1, 1'b0, 32'hDEADBEEF, 3};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h00000000, 32'h80112233, 0,   0,   1'b0, 4'h8, 1'b0, 32'h00000000, 1'b1, 1'b0, 32'hFFFFFF80, 3};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h00000000, 32'h80112233, 0,   0,   1'b0, 4'h8, 1'b0, 32'h00000000, 1'b1, 1'b0, 32'h00000080, 3};
    vecs[3]  = '{1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h00000000, 0,   0,   1'b0, 4'hC, 1'b1, 32'hABCDABCD, 1'b0, 1'b0, 32'h00000000, 2};
    vecs[4]  = '{1'b1, 1'b0, 3'b010, 32'h101, 32'h00000000, 32'h00000000, 0,   0,   1'b1, 4'h0, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 0};
    vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h00000000, 32'h80112233, 0,   0,   1'b0, 4'hC, 1'b0, 32'h00000000, 1'b1, 1'b0, 32'hFFFF8011, 3};
    vecs[6]  = '{1'b1, 1'b0, 3'b101, 32'h100, 32'h00000000, 32'h1234F00D, 0,   0,   1'b0, 4'h3, 1'b0, 32'h00000000, 1'b1, 1'b0, 32'h0000F00D, 3};
    vecs[7]  = '{1'b0, 1'b1, 3'b000, 32'h301, 32'h000000A5, 32'h00000000, 0,   0,   1'b0, 4'h2, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h00000000, 2};
    vecs[8]  = '{1'b0, 1'b1, 3'b010, 32'h404, 32'h12345678, 32'h00000000, 0,   0,   1'b0, 4'hF, 1'b1, 32'h12345678, 1'b0, 1'b0, 32'h00000000, 2};
    vecs[9]  = '{1'b1, 1'b0, 3'b001, 32'h105, 32'h00000000, 32'h00000000, 0,   0,   1'b1, 4'h0, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 0};
    vecs[10] = '{1'b0, 1'b1, 3'b001, 32'h203, 32'h00001111, 32'h00000000, 0,   0,   1'b1, 4'h0, 1'b0, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 0};
    vecs[11] = '{1'b1, 1'b0, 3'b000, 32'h101, 32'h00000000, 32'h00007F00, 0,   0,   1'b0, 4'h2, 1'b0, 32'h00000000, 1'b1, 1'b0, 32'h0000007F, 3};
    vecs[12] = '{1'b1, 1'b0, 3'b010, 32'h500, 32'h00000000, 32'hCAFEF00D, 3,   0,   1'b0, 4'hF, 1'b0, 32'h00000000, 1'b1, 1'b0, 32'hCAFEF00D, 6};
    vecs[13] = '{1'b1, 1'b0, 3'b010, 32'h504, 32'h00000000, 32'h0BADCAFE, 0,   2,   1'b0, 4'hF, 1'b0, 32'h00000000, 1'b1, 1'b0, 32'h0BADCAFE, 5};
    vecs[14] = '{1'b1, 1'b1, 3'b010, 32'h600, 32'h11111111, 32'h55AA55AA, 0,   0,   1'b0, 4'hF, 1'b0, 32'h00000000, 1'b1, 1'b0, 32'h55AA55AA, 3};
    vecs[15] = '{1'b1, 1'b0, 3'b010, 32'h700, 32'h00000000, 32'h77777777, 255, 0,   1'b0, 4'hF, 1'b0, 32'h00000000, 1'b1, 1'b1, 32'h00000000, 17};
    vecs[16] = '{1'b1, 1'b0, 3'b010, 32'h704, 32'h00000000, 32'h77777777, 0,   255, 1'b0, 4'hF, 1'b0, 32'h00000000, 1'b1, 1'b1, 32'h00000000, 17};
    vecs[17] = '{1'b0, 1'b1, 3'b010, 32'h708, 32'hFEEDF00D, 32'h00000000, 15,  0,   1'b0, 4'hF, 1'b1, 32'hFEEDF00D, 1'b0, 1'b0, 32'h00000000, 17};
    vecs[18] = '{1'b1, 1'b0, 3'b100, 32'h000, 32'h00000000, 32'hFFFFFF81, 0,   0,   1'b0, 4'h1, 1'b0, 32'h00000000, 1'b1, 1'b0, 32'h00000081, 3};
    vecs[19] = '{1'b1, 1'b0, 3'b000, 32'h000, 32'h00000000, 32'hFFFFFF81, 0,   0,   1'b0, 4'h1, 1'b0, 32'h00000000, 1'b1, 1'b0, 32'hFFFFFF81, 3};
    vecs[20] = '{1'b0, 1'b1, 3'b001, 32'h200, 32'h1234BEEF, 32'h00000000, 0,   0,   1'b0, 4'h3, 1'b1, 32'hBEEFBEEF, 1'b0, 1'b0, 32'h00000000, 2};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_bus_req", {31'h0, bus_req_o}, 32'h0);
    chk("reset_bus_we", {31'h0, bus_we_o}, 32'h0);
    chk("reset_bus_addr", bus_addr_o, 32'h0);
    chk("reset_bus_wdata", bus_wdata_o, 32'h0);
    chk("reset_bus_be", {28'h0, bus_be_o}, 32'h0);
    chk("reset_stall", {31'h0, stall_o}, 32'h0);
    chk("reset_load_data", load_data_o, 32'h0);
    chk("reset_load_valid", {31'h0, load_valid_o}, 32'h0);
    chk("reset_misalign", {31'h0, misalign_o}, 32'h0);
    chk("reset_bus_err", {31'h0, bus_err_o}, 32'h0);
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    reset_mid_wait();

    repeat (2) @(posedge clk);
    chk("busq_drained", busq.size(), 32'h0);
    chk("ldq_drained", ldq.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
